bc_msg_rr_arbiter: RTL

// - Collects broadcast messages from CORE_COUNT core wrappers (bc_msg_out/valid/ready of each core, post pipe-reg).
// - Arbitrates them round-robin into one broadcast stream, which fans out to every core's bc_msg_in/bc_msg_in_valid.
// - The destination side has no ready signal. Output is one registered beat per grant, tagged with source core ID and destination mask.

---
 rtl/bc_msg_rr_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/bc_msg_rr_arbiter.sv
// Round-robin collector of per-core broadcast messages into one registered broadcast beat.
// Each core has a one-entry holding register. A granted core can refill in the same cycle.
module bc_msg_rr_arbiter #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int MSG_WIDTH     = 47,
    parameter bit EXCLUDE_SRC   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
    input  logic [CORE_COUNT-1:0]           s_valid,
    output logic [CORE_COUNT-1:0]           s_ready,
    input  logic [CORE_COUNT-1:0]           core_en,
    input  logic                            m_hold,
    output logic [MSG_WIDTH-1:0]            m_msg,
    output logic [CORE_ID_WIDTH-1:0]        m_src,
    output logic [CORE_COUNT-1:0]           m_dest_mask,
    output logic                            m_valid,
    output logic [31:0]                     msg_count
);

    if (CORE_COUNT < 2 || CORE_ID_WIDTH < $clog2(CORE_COUNT)) begin : g_param_check
        $error("bc_msg_rr_arbiter: invalid CORE_COUNT / CORE_ID_WIDTH");
    end

    logic [CORE_COUNT-1:0]    full_p0;
    logic [MSG_WIDTH-1:0]     msg_p0 [CORE_COUNT];
    logic [CORE_COUNT-1:0]    req;
    logic [CORE_COUNT-1:0]    grant;
    logic [CORE_COUNT-1:0]    accept;
    logic [CORE_ID_WIDTH-1:0] rr_ptr;
    logic [CORE_ID_WIDTH-1:0] grant_idx;
    logic [CORE_ID_WIDTH-1:0] cand;
    logic                     grant_vld;
    int                       sum;

    // Explicit wrap so a non-power-of-two core count never points past the last core.
    function automatic logic [CORE_ID_WIDTH-1:0] ptr_inc(input logic [CORE_ID_WIDTH-1:0] p);
        if (int'(p) >= CORE_COUNT - 1) return '0;
        return p + 1'b1;
    endfunction

    assign req     = full_p0 & core_en;
    assign s_ready = rst_n ? (core_en & (~full_p0 | grant)) : '0;
    assign accept  = s_valid & s_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        sum       = 0;
        if (!m_hold) begin
            for (int k = 0; k < CORE_COUNT; k++) begin
                sum = int'(rr_ptr) + k;
                if (sum >= CORE_COUNT) sum = sum - CORE_COUNT;
                cand = sum[CORE_ID_WIDTH-1:0];
                if (!grant_vld && req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    // ---- stage p0: holding registers (payload only, no reset needed) ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (accept[i]) msg_p0[i] <= s_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
    end

    // ---- stage p0 -> output: occupancy, pointer and broadcast beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_p0     <= '0;
            rr_ptr      <= '0;
            m_valid     <= 1'b0;
            m_msg       <= '0;
            m_src       <= '0;
            m_dest_mask <= '0;
            msg_count   <= '0;
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (!core_en[i])    full_p0[i] <= 1'b0;
                else if (accept[i]) full_p0[i] <= 1'b1;
                else if (grant[i])  full_p0[i] <= 1'b0;
            end
            if (grant_vld) begin
                m_valid     <= 1'b1;
                m_msg       <= msg_p0[grant_idx];
                m_src       <= grant_idx;
                m_dest_mask <= core_en & ~(EXCLUDE_SRC ? grant : '0);
                rr_ptr      <= ptr_inc(grant_idx);
                msg_count   <= msg_count + 32'd1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
